// File: rtl/dm_lsu_pkg.sv
// rtl/dm_lsu_pkg.sv - shared encodings and helpers for the data-memory load/store unit
package dm_lsu_pkg;

  // Access size as carried on req_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS   = 2'b01,
    ST_MERGE_WR = 2'b10,
    ST_RESP     = 2'b11
  } state_e;

  // Byte lane selected by addr[1:0] (little-endian)
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  // Halfword lane selected by addr[1]
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // A request is rejected when its size is illegal or it is not naturally aligned
  function automatic logic req_bad(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = lo[0];
      SZ_WORD: req_bad = |lo;
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// rtl/dm_lsu_if.sv - request/response and RAM port bundle for the load/store unit
interface dm_lsu_if #(
  parameter int AWL = 32,
  parameter int DWL = 32
) ();
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [1:0]     req_size;
  logic           req_unsigned;
  logic [AWL-1:0] req_addr;
  logic [DWL-1:0] req_wdata;
  logic           resp_valid;
  logic           resp_err;
  logic [DWL-1:0] resp_rdata;
  logic [AWL-1:0] mem_addr;
  logic           mem_wr;
  logic [DWL-1:0] mem_din;
  logic [DWL-1:0] mem_dout;

  // Requester plus RAM side
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wr, mem_din
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wr, mem_din
  );
endinterface

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte/halfword lane extract with extension, and lane merge for stores
module dm_lane_align
  import dm_lsu_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Pick the addressed lane out of the RAM word, extend it, and build the merged store word
  always_comb begin
    b_sel   = rdata[7:0];
    h_sel   = rdata[15:0];
    ld_data = rdata;
    st_data = wdata;

    case (addr_lo)
      LANE_B0: b_sel = rdata[7:0];
      LANE_B1: b_sel = rdata[15:8];
      LANE_B2: b_sel = rdata[23:16];
      default: b_sel = rdata[31:24];
    endcase
    h_sel = (addr_lo[1] == HALF_HI) ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: begin
        ld_data = {{24{b_sel[7] & ~uns}}, b_sel};
        st_data = rdata;
        case (addr_lo)
          LANE_B0: st_data[7:0]   = wdata[7:0];
          LANE_B1: st_data[15:8]  = wdata[7:0];
          LANE_B2: st_data[23:16] = wdata[7:0];
          default: st_data[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        ld_data = {{16{h_sel[15] & ~uns}}, h_sel};
        st_data = rdata;
        if (addr_lo[1] == HALF_HI) st_data[31:16] = wdata[15:0];
        else                       st_data[15:0]  = wdata[15:0];
      end
      default: begin
        ld_data = rdata;
        st_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - MEM-stage load/store unit, sole initiator on the word-wide data RAM
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int AWL = 32,
  parameter int DWL = 32
) (
  input  logic    CLK,
  input  logic    RST_N,
  dm_lsu_if.slave bus
);

  state_e         state;
  logic           we_q;
  size_e          size_q;
  logic           uns_q;
  logic [AWL-1:0] addr_q;
  logic [DWL-1:0] wdata_q;
  logic [DWL-1:0] din_q;
  logic           wr_q;
  logic           rvalid_q;
  logic           rerr_q;
  logic [DWL-1:0] rdata_q;
  logic [DWL-1:0] ld_data;
  logic [DWL-1:0] st_data;

  dm_lane_align u_align (
    .size    (size_q),
    .uns     (uns_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (bus.mem_dout),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // Gated by reset so ready is low while held in reset and high right after release
  assign bus.req_ready  = RST_N && (state == ST_IDLE);
  assign bus.mem_addr   = {2'b00, addr_q[AWL-1:2]};
  assign bus.mem_wr     = wr_q;
  assign bus.mem_din    = din_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata = rdata_q;

  // Control FSM with request latch and registered RAM/response outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            size_q  <= size_e'(bus.req_size);
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (req_bad(size_e'(bus.req_size), bus.req_addr[1:0])) begin
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
              rdata_q  <= '0;
              state    <= ST_RESP;
            end else begin
              // Full-word stores need no read, so the write goes out during ACCESS
              if (bus.req_we && size_e'(bus.req_size) == SZ_WORD) begin
                wr_q  <= 1'b1;
                din_q <= bus.req_wdata;
              end
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            rdata_q  <= ld_data;
            rvalid_q <= 1'b1;
            state    <= ST_RESP;
          end else if (size_q == SZ_WORD) begin
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b1;
            state    <= ST_RESP;
          end else begin
            din_q <= st_data;
            wr_q  <= 1'b1;
            state <= ST_MERGE_WR;
          end
        end
        ST_MERGE_WR: begin
          wr_q     <= 1'b0;
          rdata_q  <= '0;
          rvalid_q <= 1'b1;
          state    <= ST_RESP;
        end
        default: begin
          rvalid_q <= 1'b0;
          rerr_q   <= 1'b0;
          rdata_q  <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - directed and randomized checks of dm_lsu against a word-array reference model
module tb_dm_lsu;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] ram [0:63];
  logic [31:0] mdl [0:63];
  logic        ld_en;

  dm_lsu_if #(.AWL(32), .DWL(32)) bus ();

  dm_lsu #(.AWL(32), .DWL(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = ram[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 64; i++) ram[i] <= mdl[i];
    end else if (bus.mem_wr) begin
      ram[bus.mem_addr[5:0]] <= bus.mem_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    w = mdl[(a / 4) % 64];
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    int sh;
    w = mdl[(a / 4) % 64];
    if (sz == 2'd2) return wd;
    if (sz == 2'd0) begin
      sh = 8 * (a % 4);
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    sh = 16 * ((a / 2) % 2);
    return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
  endfunction

  task automatic run_req(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    int resp_cyc, resp_cnt, wr_cyc, wr_cnt, rdy_cyc;
    int exp_resp, exp_wr;
    logic [31:0] wr_din, wr_addr, exp_rd, exp_din;
    logic err_seen;
    bit   bad;
    resp_cyc = -1; resp_cnt = 0; wr_cyc = -1; wr_cnt = 0; rdy_cyc = -1;
    wr_din = '0; wr_addr = '0; err_seen = 1'b0; rd = '0;

    check({tag, ".ready0"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.mem_wr) begin
        wr_cnt++;
        if (wr_cyc < 0) begin
          wr_cyc  = k;
          wr_din  = bus.mem_din;
          wr_addr = bus.mem_addr;
        end
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        if (resp_cyc < 0) begin
          resp_cyc = k;
          rd       = bus.resp_rdata;
          err_seen = bus.resp_err;
        end
      end
      if (bus.req_ready && rdy_cyc < 0) rdy_cyc = k;
    end

    bad = model_err(sz, a);
    exp_rd = 32'd0;
    exp_din = 32'd0;
    exp_wr = -1;
    if (bad) exp_resp = 1;
    else if (!we) begin
      exp_resp = 2;
      exp_rd = model_load(sz, uns, a);
    end else if (sz == 2'd2) begin
      exp_resp = 2; exp_wr = 1;
      exp_din = model_store(sz, a, wd);
    end else begin
      exp_resp = 3; exp_wr = 2;
      exp_din = model_store(sz, a, wd);
    end

    check({tag, ".resp_cyc"}, resp_cyc, exp_resp);
    check({tag, ".resp_cnt"}, resp_cnt, 32'd1);
    check({tag, ".err"}, {31'd0, err_seen}, {31'd0, bad});
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".ready_cyc"}, rdy_cyc, exp_resp + 1);
    check({tag, ".wr_cnt"}, wr_cnt, (exp_wr < 0) ? 32'd0 : 32'd1);
    if (exp_wr > 0) begin
      check({tag, ".wr_cyc"}, wr_cyc, exp_wr);
      check({tag, ".wr_din"}, wr_din, exp_din);
      check({tag, ".wr_addr"}, wr_addr, a / 4);
      mdl[(a / 4) % 64] = exp_din;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int cnt;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ld_en = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) mdl[i] = $urandom;
    mdl[4] = 32'h807060F0;
    mdl[5] = 32'h11223344;

    repeat (3) @(negedge clk);
    check("rst.ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst.mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst.resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    ld_en = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst.ready_after", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);

    run_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check("lw10.const", rd, 32'h807060F0);
    run_req("lb10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd);
    check("lb10.const", rd, 32'hFFFFFFF0);
    run_req("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd);
    check("lbu13.const", rd, 32'h00000080);
    run_req("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);
    check("lh12.const", rd, 32'hFFFF8070);
    run_req("lhu10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd);
    check("lhu10.const", rd, 32'h000060F0);
    run_req("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, rd);
    run_req("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check("lw10b.const", rd, 32'h8070ABF0);
    run_req("sw14", 1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, rd);
    run_req("lw14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd);
    check("lw14.const", rd, 32'hDEADBEEF);
    run_req("lh11", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd);
    run_req("sw16", 1'b1, 2'd2, 1'b0, 32'h16, 32'h12345678, rd);
    run_req("ill", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd);

    // Reset landing in the middle of a read-modify-write
    check("rstmw.ready0", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd1;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h12;
    bus.req_wdata = 32'h0000CAFE;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstmw.wr_before", {31'd0, bus.mem_wr}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmw.wr_async", {31'd0, bus.mem_wr}, 32'd0);
    check("rstmw.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rstmw.ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("rstmw.ram_kept", ram[4], mdl[4]);
    rst_n = 1'b1;
    #1;
    check("rstmw.ready_after", {31'd0, bus.req_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) cnt++;
    end
    check("rstmw.no_resp", cnt, 32'd0);
    run_req("rstmw.lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);

    for (int n = 0; n < 60; n++) begin
      run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, rd);
    end

    for (int i = 0; i < 64; i++) check($sformatf("ram%0d", i), ram[i], mdl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit for the pipelined MIPS MEM stage; sole initiator on the data-memory RAM port. Accepts one byte/halfword/word load or store per handshake, word-addresses the RAM, sign/zero-extends loads, and implements sub-word stores as read-modify-write on the word-wide RAM. Misaligned or illegal-size requests are rejected without touching memory.

## Interface
- AWL, 32, byte-address width (CPU side) and RAM address width
- DWL, 32, data width; fixed at 32 (four byte lanes)
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  AWL  byte address
- req_wdata  in  DWL  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_err  out  1  misaligned/illegal request, valid with resp_valid
- resp_rdata  out  DWL  load result, valid with resp_valid; 0 for stores and errors
- mem_addr  out  AWL  word address = req_addr >> 2 (top two bits zero)
- mem_wr  out  1  RAM write enable, sampled by RAM on CLK rising edge
- mem_din  out  DWL  RAM write data
- mem_dout  in  DWL  RAM combinational read data for mem_addr

## Operation
- States: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE: req_ready=1. On req_valid: latch we/size/unsigned/addr/wdata. If error → RESP with err flag set; else → ACCESS.
- Error: size 11; half with addr[0]=1; word with addr[1:0]≠0. No RAM access.
- ACCESS: mem_addr from latched addr.
  - Load: extract lane from mem_dout, extend, register into resp_rdata → RESP.
  - Word store: mem_wr=1, mem_din=wdata → RESP.
  - Byte/half store: capture mem_dout with selected lane(s) replaced by wdata → MERGE_WR.
- MERGE_WR: mem_wr=1, mem_din=merged word → RESP.
- RESP: resp_valid=1 for exactly one cycle → IDLE.
- Lane order little-endian: addr[1:0]=0 selects bits [7:0]; half at addr[1]=0 is [15:0], addr[1]=1 is [31:16].
- mem_wr is 0 in every state except as listed; mem_addr/mem_din hold last latched values otherwise.

## Timing
- Request accepted at edge ending cycle 0.
- Load: ACCESS cycle 1, resp_valid cycle 2, req_ready again cycle 3.
- Word store: mem_wr cycle 1, resp_valid cycle 2.
- Sub-word store: read cycle 1, mem_wr cycle 2, resp_valid cycle 3.
- Error: resp_valid cycle 1, resp_err=1, resp_rdata=0.
- Reset (RST_N low, any time): state→IDLE immediately; mem_wr, resp_valid, resp_err, req_ready=0, resp_rdata=0, all latches cleared. In-flight request discarded, no response. req_ready=1 from first cycle after release.
- req_valid in non-IDLE states ignored (req_ready=0); requester must hold.
- A write completed before reset is retained in RAM; MERGE_WR interrupted by reset writes nothing.

## Structure
- Shared package/header dm_lsu_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state encodings, lane-select constants.
- Sub-module dm_lane_align (combinational): lane extract + sign/zero-extend for loads, lane merge for stores.
- FSM, request latch, response register in dm_lsu.

## Test plan
- RAM word 4 = 0x807060F0; LW addr 0x10 → resp_valid cycle 2, resp_rdata 0x807060F0, resp_err 0.
- Same word: LB 0x10 → 0xFFFFFFF0; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF8070; LHU 0x10 → 0x000060F0.
- SB wdata 0x000000AB addr 0x11 → mem_wr only in cycle 2, mem_addr 4, mem_din 0x8070ABF0, resp_valid cycle 3; follow-up LW 0x10 returns 0x8070ABF0.
- SW 0xDEADBEEF addr 0x14 → mem_wr cycle 1, mem_din 0xDEADBEEF; LW 0x14 returns 0xDEADBEEF.
- LH 0x11, SW 0x16, size 11 → each resp_err=1 in cycle 1, resp_rdata 0, mem_wr never asserted.
- SH to 0x12, RST_N low during MERGE_WR → mem_wr drops asynchronously, no resp_valid, RAM word unchanged, req_ready=1 cycle after release.
